// File: rtl/pipe_add_sub_if.sv
// Operand/result bus for pipe_add_sub: valid/ready in both directions.
interface pipe_add_sub_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic             carry_in;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_1, in_2, carry_in, sub, in_valid, out_ready,
        input  in_ready, sum, carry_out, overflow, out_valid
    );

    modport slave (
        input  in_1, in_2, carry_in, sub, in_valid, out_ready,
        output in_ready, sum, carry_out, overflow, out_valid
    );
endinterface

// File: rtl/pipe_add_sub.sv
// Chunked pipelined adder/subtractor: one C-bit chunk per stage, operands
// skewed in, sum chunks deskewed out, latency STAGES, stall on out_ready.
module pipe_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic           clk,
    input logic           rst,
    pipe_add_sub_if.slave bus
);
    localparam int C = WIDTH / STAGES;

    logic             en;
    logic             in_v;
    logic             in_c;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    assign en          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    // Acceptance register: B is inverted and the carry forced to 1 for subtract.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_v <= 1'b0;
        end else if (en) begin
            in_v <= bus.in_valid;
            in_a <= bus.in_1;
            in_b <= bus.sub ? ~bus.in_2 : bus.in_2;
            in_c <= bus.sub | bus.carry_in;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = (k + 1) * C;
        localparam int HI = WIDTH - LO;

        logic          v;
        logic          cy;
        logic [LO-1:0] s;
        logic [C-1:0]  a_c;
        logic [C-1:0]  b_c;
        logic          c_i;
        logic          v_i;
        logic [LO-1:0] s_n;
        logic [C:0]    add;

        if (k == 0) begin : src
            assign a_c = in_a[C-1:0];
            assign b_c = in_b[C-1:0];
            assign c_i = in_c;
            assign v_i = in_v;
            assign s_n = add[C-1:0];
        end else begin : src
            assign a_c = stg[k-1].sk.a_sk[C-1:0];
            assign b_c = stg[k-1].sk.b_sk[C-1:0];
            assign c_i = stg[k-1].cy;
            assign v_i = stg[k-1].v;
            assign s_n = {add[C-1:0], stg[k-1].s};
        end

        assign add = {1'b0, a_c} + {1'b0, b_c} + {{C{1'b0}}, c_i};

        always_ff @(posedge clk) begin
            if (rst) begin
                v  <= 1'b0;
                cy <= 1'b0;
                s  <= '0;
            end else if (en) begin
                v  <= v_i;
                cy <= add[C];
                s  <= s_n;
            end
        end

        // Skew registers: the operand chunks not yet consumed, low chunk next.
        if (HI > 0) begin : sk
            logic [HI-1:0] a_sk;
            logic [HI-1:0] b_sk;
            logic [HI-1:0] a_up;
            logic [HI-1:0] b_up;

            if (k == 0) begin : up
                assign a_up = in_a[WIDTH-1:C];
                assign b_up = in_b[WIDTH-1:C];
            end else begin : up
                assign a_up = stg[k-1].sk.a_sk[HI+C-1:C];
                assign b_up = stg[k-1].sk.b_sk[HI+C-1:C];
            end

            always_ff @(posedge clk) begin
                if (en) begin
                    a_sk <= a_up;
                    b_sk <= b_up;
                end
            end
        end

        if (k == STAGES - 1) begin : fin
            logic ovf;
            // a^b^s at the MSB recovers the carry into it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf <= 1'b0;
                end else if (en) begin
                    ovf <= a_c[C-1] ^ b_c[C-1] ^ add[C-1] ^ add[C];
                end
            end
        end
    end

    assign bus.sum       = stg[STAGES-1].s;
    assign bus.carry_out = stg[STAGES-1].cy;
    assign bus.out_valid = stg[STAGES-1].v;
    assign bus.overflow  = stg[STAGES-1].fin.ovf;
endmodule

// File: tb/tb_pipe_add_sub.sv
// Scoreboard bench for pipe_add_sub (WIDTH=16, STAGES=4): directed corner
// cases, stall, mid-flight reset and a long randomized handshake run.
module tb_pipe_add_sub;
    localparam int W = 16;
    localparam int S = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        int unsigned  acc;
        bit           lat;
    } exp_t;

    logic clk;
    logic rst;
    pipe_add_sub_if #(.WIDTH(W)) bus ();

    pipe_add_sub #(.WIDTH(W), .STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned out_count = 0;
    exp_t        exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic ci);
        exp_t e;
        int ua, ub, sa, sb, full, sfull;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            full  = ua - ub;
            sfull = sa - sb;
            e.co  = (ua >= ub);
        end else begin
            full  = ua + ub + int'(ci);
            sfull = sa + sb + int'(ci);
            e.co  = (full > 65535);
        end
        e.sum = W'(full & 32'hFFFF);
        e.ov  = (sfull > 32767) || (sfull < -32768);
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov);
        exp_t e;
        e.sum = s;
        e.co  = co;
        e.ov  = ov;
        e.acc = 0;
        e.lat = 1'b1;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] corner [4];
        corner[0] = 16'h0000;
        corner[1] = 16'hFFFF;
        corner[2] = 16'h7FFF;
        corner[3] = 16'h8000;
        if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ci, input exp_t e);
        int unsigned guard = 0;
        bus.in_1     = a;
        bus.in_2     = b;
        bus.sub      = s;
        bus.carry_in = ci;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops on every result transfer, independent of the driver.
    always @(negedge clk) begin
        #2;
        if (!rst && bus.out_valid && bus.out_ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got sum 0x%0h expected no result", bus.sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", {15'd0, bus.sum, bus.carry_out, bus.overflow},
                      {15'd0, e.sum, e.co, e.ov});
                if (e.lat) check("latency", cyc - e.acc, 32'(S));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ta [8];
        logic [W-1:0] tb [8];
        logic         ts [8];
        logic         tc [8];
        logic [W-1:0] first_sum;
        int unsigned  base;

        rst          = 1'b1;
        bus.in_1     = '0;
        bus.in_2     = '0;
        bus.sub      = 1'b0;
        bus.carry_in = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result", {15'd0, bus.sum, bus.carry_out, bus.overflow}, 32'd0);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // Directed corners, each with latency checked.
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0));
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        drain();
        send(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        drain();
        send(16'h8000, 16'h0001, 1'b1, 1'b0, mk(16'h7FFF, 1'b1, 1'b1));
        drain();
        send(16'h1234, 16'h0FFF, 1'b0, 1'b1, mk(16'h2234, 1'b0, 1'b0));
        drain();

        // Stream 8 with a 3-cycle stall starting at the first result.
        for (int i = 0; i < 8; i++) begin
            ta[i] = rnd_op();
            tb[i] = rnd_op();
            ts[i] = (i % 2 == 1);
            tc[i] = 1'(i % 3 == 0);
        end
        first_sum = model(ta[0], tb[0], ts[0], tc[0]).sum;
        base = out_count;
        fork
            begin
                for (int i = 0; i < 8; i++) send(ta[i], tb[i], ts[i], tc[i], model(ta[i], tb[i], ts[i], tc[i]));
            end
            begin
                int unsigned g = 0;
                do begin
                    @(negedge clk);
                    g++;
                end while (!bus.out_valid && g < 50);
                check("stall_first_valid", 32'(bus.out_valid), 32'd1);
                bus.out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    #1;
                    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    check("stall_hold", {15'd0, bus.out_valid, bus.sum}, {15'd0, 1'b1, first_sum});
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    #3;
                    check("stream_per_cycle", 32'(bus.out_valid), 32'd1);
                    @(negedge clk);
                end
            end
        join
        drain();
        check("stream_count", out_count - base, 32'd8);

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) send(rnd_op(), rnd_op(), 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0));
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_sum", 32'(bus.sum), 32'd0);
        base = out_count;
        send(16'h4000, 16'h4000, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        send(16'h0003, 16'h0003, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        send(16'h0000, 16'h0000, 1'b0, 1'b1, mk(16'h0001, 1'b0, 1'b0));
        drain();
        repeat (6) @(negedge clk);
        check("flush_count", out_count - base, 32'd3);

        // Randomized handshakes on both sides.
        begin
            int unsigned sent = 0;
            int unsigned guard = 0;
            while (sent < 10000 && guard < 60000) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_1      = rnd_op();
                bus.in_2      = rnd_op();
                bus.sub       = 1'($urandom_range(0, 1));
                bus.carry_in  = 1'($urandom_range(0, 1));
                #1;
                if (bus.in_valid && bus.in_ready) begin
                    exp_t e;
                    e = model(bus.in_1, bus.in_2, bus.sub, bus.carry_in);
                    exp_q.push_back(e);
                    sent++;
                end
                @(negedge clk);
                guard++;
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            check("random_sent", sent, 32'd10000);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_add_sub.md
PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 The module SHALL have parameter STAGES, default 4: number of pipeline chunks; WIDTH mod STAGES = 0 and 1 <= STAGES <= WIDTH.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port in_1, input, WIDTH bits: operand A.
REQ-006 The module SHALL have port in_2, input, WIDTH bits: operand B.
REQ-007 The module SHALL have port carry_in, input, 1 bit: carry into bit 0 for add mode; ignored in subtract mode.
REQ-008 The module SHALL have port sub, input, 1 bit: 0 means A+B+carry_in, 1 means A-B (A + ~B + 1).
REQ-009 The module SHALL have port in_valid, input, 1 bit: operands valid.
REQ-010 The module SHALL have port in_ready, output, 1 bit: module accepts operands this cycle.
REQ-011 The module SHALL have port sum, output, WIDTH bits: result, low WIDTH bits.
REQ-012 The module SHALL have port carry_out, output, 1 bit: carry out of MSB; in subtract mode 1 means no borrow.
REQ-013 The module SHALL have port overflow, output, 1 bit: two's-complement signed overflow of the operation.
REQ-014 The module SHALL have port out_valid, output, 1 bit: sum/carry_out/overflow valid.
REQ-015 The module SHALL have port out_ready, input, 1 bit: downstream accepts result.

Function
REQ-016 Operand transfer SHALL occur on a clock edge where in_valid and in_ready are both 1; result transfer where out_valid and out_ready are both 1.
REQ-017 Operands SHALL be split into STAGES chunks of C = WIDTH/STAGES bits; pipeline stage k (0..STAGES-1) adds chunk k plus the registered carry from stage k-1 (stage 0 uses carry_in, or 1 when sub=1).
REQ-018 Unprocessed upper operand chunks SHALL be carried forward in skew registers and completed lower sum chunks in deskew registers, so all chunks of one transaction emerge together.
REQ-019 In subtract mode, B SHALL be bitwise inverted at acceptance; the sub bit travels with the transaction.
REQ-020 Latency SHALL be exactly STAGES cycles: a transaction accepted at edge n raises out_valid after edge n+STAGES when no stall occurs.
REQ-021 Throughput SHALL be one transaction per cycle with out_ready held 1.
REQ-022 Pipeline advance enable SHALL be en = !out_valid | out_ready; in_ready SHALL equal en; when en=0 every pipeline register, including each per-stage valid bit, holds its value.
REQ-023 While out_valid=1 and out_ready=0, sum, carry_out and overflow SHALL remain stable until the transfer.
REQ-024 Bubbles (in_valid=0 with en=1) SHALL propagate as per-stage valid=0; data registers of invalid stages are don't-care, but outputs SHALL be stable whenever out_valid=1.
REQ-025 overflow SHALL be carry into MSB XOR carry out of MSB, computed in the final stage.
REQ-026 For STAGES=1 the block SHALL reduce to a single registered adder with latency 1.
REQ-027 Back-to-back transactions of mixed sub values SHALL not interact; each result depends only on its own operands, sub and carry_in.

Reset
REQ-028 With rst=1 at a clock edge, all per-stage valid bits, out_valid, sum, carry_out and overflow SHALL be 0 after that edge; in-flight transactions are discarded.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts; rst SHALL take priority over any transfer in the same cycle.

Verification (WIDTH=16, STAGES=4, out_ready=1 unless stated)
REQ-030 The bench SHALL drive A=0x00FF, B=0x0001, sub=0, carry_in=0 and require sum=0x0100, carry_out=0, overflow=0, with out_valid 4 cycles after acceptance (carry crosses chunk 1 to 2).
REQ-031 The bench SHALL drive A=0xFFFF, B=0x0001, sub=0, carry_in=0 and require sum=0x0000, carry_out=1, overflow=0; A=0x7FFF, B=0x0001 SHALL give sum=0x8000, carry_out=0, overflow=1.
REQ-032 The bench SHALL drive A=0x0005, B=0x0007, sub=1, carry_in=1 (ignored) and require sum=0xFFFE, carry_out=0, overflow=0; A=0x8000, B=0x0001, sub=1 SHALL give sum=0x7FFF, carry_out=1, overflow=1.
REQ-033 The bench SHALL stream 8 transactions with in_valid held 1 and hold out_ready=0 from the first out_valid for 3 cycles; it SHALL require in_ready=0 during the stall, a stable first result, all 8 results in order with no loss or duplication, and one result per cycle after release.
REQ-034 The bench SHALL assert rst for 1 cycle with 3 transactions in flight and require out_valid=0 and sum=0 afterwards, no stale results, and correct results for new transactions issued immediately after.
REQ-035 The bench SHALL run 10,000 random transactions with random in_valid/out_ready against a reference model of (A ± B + cin) mod 2^16 and require zero mismatches.
